// File: rtl/deserializer_align_if.sv
// Serial receive bundle between the serdes bit stream and the byte aligner.
// The slave side is the aligner; the master side feeds bits and observes bytes.
interface deserializer_align_if;
    logic       enb;
    logic       serial_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    modport slave (
        input  enb,
        input  serial_in,
        output data_out,
        output valid_out,
        output active
    );

    modport master (
        output enb,
        output serial_in,
        input  data_out,
        input  valid_out,
        input  active
    );
endinterface

// File: rtl/deserializer_align.sv
// Serial-to-parallel byte aligner: hunts for SYNC_BYTE, locks after SYNC_COUNT aligned syncs.
// Build option DESER_PASS_SYNC_EN: deliver sync bytes seen while locked as ordinary data.
//
// state  | meaning
// SEARCH | sliding bit-by-bit compare for the sync byte
// LOCK   | byte-aligned, counting consecutive sync bytes
// ACTIVE | locked; non-sync bytes are delivered with valid_out
module deserializer_align #(
    parameter logic [7:0]  SYNC_BYTE  = 8'hBC,
    parameter int unsigned SYNC_COUNT = 4
) (
    input  logic clk,
    input  logic reset,
    deserializer_align_if.slave bus
);
    localparam logic [3:0] SYNC_TARGET = 4'(SYNC_COUNT);

    typedef enum logic [1:0] {SEARCH, LOCK, ACTIVE} state_t;

    state_t     state, state_nx;
    // Only the last seven bits are kept; the live bit completes the 8-bit window.
    logic [6:0] hist, hist_nx;
    logic [2:0] bit_cnt, bit_cnt_nx;
    logic [3:0] sync_cnt, sync_cnt_nx;
    logic [7:0] data_r, data_nx;
    logic       valid_r, valid_nx;
    logic [7:0] window;
    logic       sync_hit;
    logic       boundary;

    assign window   = {hist, bus.serial_in};
    assign sync_hit = (window == SYNC_BYTE);
    assign boundary = (bit_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SEARCH;
            hist     <= '0;
            bit_cnt  <= '0;
            sync_cnt <= '0;
            data_r   <= '0;
            valid_r  <= 1'b0;
        end else begin
            state    <= state_nx;
            hist     <= hist_nx;
            bit_cnt  <= bit_cnt_nx;
            sync_cnt <= sync_cnt_nx;
            data_r   <= data_nx;
            valid_r  <= valid_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        hist_nx     = hist;
        bit_cnt_nx  = bit_cnt;
        sync_cnt_nx = sync_cnt;
        data_nx     = data_r;
        valid_nx    = 1'b0;
        if (bus.enb) begin
            hist_nx    = window[6:0];
            bit_cnt_nx = bit_cnt + 3'd1;
            case (state)
                SEARCH: begin
                    if (sync_hit) begin
                        bit_cnt_nx  = 3'd0;
                        sync_cnt_nx = 4'd1;
                        state_nx    = (SYNC_COUNT == 1) ? ACTIVE : LOCK;
                    end
                end
                LOCK: begin
                    if (boundary) begin
                        if (sync_hit) begin
                            sync_cnt_nx = sync_cnt + 4'd1;
                            if (sync_cnt + 4'd1 == SYNC_TARGET)
                                state_nx = ACTIVE;
                        end else begin
                            sync_cnt_nx = 4'd0;
                            state_nx    = SEARCH;
                        end
                    end
                end
                ACTIVE: begin
                    if (boundary) begin
`ifdef DESER_PASS_SYNC_EN
                        data_nx  = window;
                        valid_nx = 1'b1;
`else
                        if (!sync_hit) begin
                            data_nx  = window;
                            valid_nx = 1'b1;
                        end
`endif
                    end
                end
                default: state_nx = SEARCH;
            endcase
        end
    end

    assign bus.data_out  = data_r;
    assign bus.valid_out = valid_r;
    assign bus.active    = (state == ACTIVE);
endmodule

// File: tb/tb_deserializer_align.sv
// Directed + randomized bench for deserializer_align against a bit-stream reference model.
module tb_deserializer_align;
    localparam logic [7:0] SB = 8'hBC;
    localparam int         SC = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    deserializer_align_if bus();

    deserializer_align #(.SYNC_BYTE(SB), .SYNC_COUNT(SC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

`ifdef DESER_PASS_SYNC_EN
    localparam bit PASS = 1'b1;
`else
    localparam bit PASS = 1'b0;
`endif

    // Reference model: counts sampled bits, remembers where alignment was found,
    // and treats every 8th bit after that anchor as a byte boundary.
    int         m_mode;   // 0 hunting, 1 counting syncs, 2 locked
    int         m_n;
    int         m_anchor;
    int         m_runs;
    logic [7:0] m_win;
    logic [7:0] m_data;
    logic       m_valid;
    logic       prev_valid;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic e, input logic b, input logic r);
        m_valid = 1'b0;
        if (r) begin
            m_mode = 0; m_n = 0; m_anchor = 0; m_runs = 0;
            m_win = 8'h00; m_data = 8'h00;
        end else if (e) begin
            m_n++;
            m_win = {m_win[6:0], b};
            if (m_mode == 0) begin
                if (m_win == SB) begin
                    m_anchor = m_n;
                    m_runs   = 1;
                    m_mode   = (SC == 1) ? 2 : 1;
                end
            end else if ((m_n - m_anchor) % 8 == 0) begin
                if (m_mode == 1) begin
                    if (m_win == SB) begin
                        m_runs++;
                        if (m_runs == SC) m_mode = 2;
                    end else begin
                        m_mode = 0;
                        m_runs = 0;
                    end
                end else if (m_win != SB || PASS) begin
                    m_data  = m_win;
                    m_valid = 1'b1;
                end
            end
        end
    endtask

    task automatic step(input logic e, input logic b, input logic r);
        bus.enb       = e;
        bus.serial_in = b;
        reset         = r;
        @(posedge clk);
        model_edge(e, b, r);
        #1;
        chk("data_out",  bus.data_out,  m_data);
        chk("valid_out", {7'd0, bus.valid_out}, {7'd0, m_valid});
        chk("active",    {7'd0, bus.active},    {7'd0, logic'(m_mode == 2)});
        if (bus.valid_out && prev_valid)
            chk("strobe_width", 8'd1, 8'd0);
        prev_valid = bus.valid_out;
    endtask

    task automatic send_byte(input logic [7:0] v, input int gap_pct);
        for (int i = 7; i >= 0; i--) begin
            if ($urandom_range(0, 99) < gap_pct)
                repeat ($urandom_range(1, 3)) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
            step(1'b1, v[i], 1'b0);
        end
    endtask

    task automatic do_reset();
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
    endtask

    initial begin
        logic [7:0] v;
        prev_valid = 1'b0;
        m_mode = 0; m_n = 0; m_anchor = 0; m_runs = 0;
        m_win = 8'h00; m_data = 8'h00; m_valid = 1'b0;
        bus.enb = 1'b0; bus.serial_in = 1'b0; reset = 1'b1;

        // 1: reset with enb high and toggling data
        do_reset();
        step(1'b0, 1'b0, 1'b0);
        chk("rst_data", bus.data_out, 8'h00);
        chk("rst_valid", {7'd0, bus.valid_out}, 8'h00);
        chk("rst_active", {7'd0, bus.active}, 8'h00);

        // 2: lock on four syncs
        repeat (SC) send_byte(SB, 0);
        chk("lock_active", {7'd0, bus.active}, 8'h01);

        // 3: first data byte
        send_byte(8'h88, 0);
        chk("data88_valid", {7'd0, bus.valid_out}, 8'h01);
        chk("data88_value", bus.data_out, 8'h88);
        step(1'b1, 1'b0, 1'b0);
        chk("data88_strobe_end", {7'd0, bus.valid_out}, 8'h00);

        // 4: misaligned prefix
        do_reset();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (SC) send_byte(SB, 0);
        send_byte(8'h5A, 0);
        chk("misalign_value", bus.data_out, 8'h5A);
        chk("misalign_valid", {7'd0, bus.valid_out}, 8'h01);

        // 5: lock aborted by a non-sync byte
        do_reset();
        send_byte(SB, 0);
        send_byte(SB, 0);
        send_byte(8'h55, 0);
        chk("abort_active", {7'd0, bus.active}, 8'h00);
        repeat (SC) send_byte(SB, 0);
        send_byte(8'hF0, 0);
        chk("abort_value", bus.data_out, 8'hF0);

        // 6: enb gap inside a byte, then a sync byte in the data stream
        do_reset();
        repeat (SC) send_byte(SB, 0);
        v = 8'h88;
        for (int i = 7; i >= 4; i--) step(1'b1, v[i], 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        for (int i = 3; i >= 1; i--) step(1'b1, v[i], 1'b0);
        chk("gap_no_early_valid", {7'd0, bus.valid_out}, 8'h00);
        step(1'b1, v[0], 1'b0);
        chk("gap_valid", {7'd0, bus.valid_out}, 8'h01);
        chk("gap_value", bus.data_out, 8'h88);
        send_byte(SB, 0);
        chk("sync_in_data_valid", {7'd0, bus.valid_out}, {7'd0, PASS});
        chk("sync_in_data_value", bus.data_out, PASS ? SB : 8'h88);

        // randomized streams with gaps, partial locks and mid-stream resets
        for (int r = 0; r < 10; r++) begin
            do_reset();
            repeat ($urandom_range(0, 7)) step(1'b1, 1'($urandom_range(0, 1)), 1'b0);
            for (int k = 0; k < 14; k++) begin
                if (k <= SC)
                    v = ($urandom_range(0, 5) == 0) ? 8'($urandom) : SB;
                else
                    v = ($urandom_range(0, 5) == 0) ? SB : 8'($urandom);
                if (r == 7 && k == 8)
                    step(1'b1, 1'b1, 1'b1);
                send_byte(v, 20);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
